// File: rtl/osc_square_cfg_calc.sv
// osc_square_cfg_calc
// Configuration front-end for the square-wave oscillator. Converts a requested
// frequency (Hz) and a fractional duty into the cr_clock_enable / cr_duty_cycle
// values the oscillator consumes:
//   Q = PRIME_FREQUENCY_P / frequency   (restoring divider, one bit per cycle)
//   Q clamped to [1, 2^N_BITS_P-1]
//   D = (Q * duty) >> DUTY_WIDTH_P      (shift-add multiplier, truncating)
// Both values are committed on the same edge together with a cr_update pulse.
// A request with frequency 0 is rejected with a one-cycle cfg_error pulse.
//
// Build option: define OSC_SQUARE_CFG_CALC_ROUND_EN to round the division to
// nearest (dividend PRIME_FREQUENCY_P + frequency/2, one extra divide cycle).
// Undefined (default) the division truncates.
module osc_square_cfg_calc #(
  parameter int PRIME_FREQUENCY_P = 1_000_000,
  parameter int N_BITS_P          = 20,
  parameter int FREQ_WIDTH_P      = 24,
  parameter int DUTY_WIDTH_P      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [FREQ_WIDTH_P-1:0] cfg_frequency,
  input  logic [DUTY_WIDTH_P-1:0] cfg_duty,
  output logic [N_BITS_P-1:0]     cr_clock_enable,
  output logic [N_BITS_P-1:0]     cr_duty_cycle,
  output logic                    cr_update,
  output logic                    cfg_error
);

  localparam int QW = $clog2(PRIME_FREQUENCY_P + 1);
`ifdef OSC_SQUARE_CFG_CALC_ROUND_EN
  localparam int DIV_STEPS = QW + 1;
`else
  localparam int DIV_STEPS = QW;
`endif
  // Dividend is wide enough for PRIME + frequency/2 in the rounding build.
  localparam int DVW  = ((QW > FREQ_WIDTH_P) ? QW : FREQ_WIDTH_P) + 1;
  localparam int RW   = FREQ_WIDTH_P + 1;
  localparam int PW   = N_BITS_P + DUTY_WIDTH_P;
  localparam int QXW  = (DIV_STEPS > N_BITS_P) ? DIV_STEPS : N_BITS_P;
  localparam int CMAX = (DIV_STEPS > DUTY_WIDTH_P) ? DIV_STEPS : DUTY_WIDTH_P;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [QXW-1:0] QMAX = QXW'({N_BITS_P{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVIDE,
    S_CLAMP,
    S_MULTIPLY,
    S_COMMIT,
    S_ERROR
  } state_t;

  state_t                  state;
  logic [FREQ_WIDTH_P-1:0] freq_q;
  logic [DUTY_WIDTH_P-1:0] duty_q;
  logic [RW-1:0]           rem;
  logic [DIV_STEPS-1:0]    quo;
  logic [CW-1:0]           cnt;
  logic [N_BITS_P-1:0]     q_clamp;
  logic [PW-1:0]           acc;
  logic [PW-1:0]           mcand;
  logic [DUTY_WIDTH_P-1:0] mplier;

  logic [DVW-1:0]          dividend;
  logic [RW-1:0]           trial;
  logic [RW-1:0]           diff;
  logic                    ge;
  logic [QXW-1:0]          qx;
  logic [N_BITS_P-1:0]     clamp_val;

  // Dividend for the incoming request; rounding adds half the divisor.
  always_comb begin
    dividend = DVW'(PRIME_FREQUENCY_P);
`ifdef OSC_SQUARE_CFG_CALC_ROUND_EN
    dividend = dividend + DVW'(cfg_frequency >> 1);
`endif
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  always_comb begin
    trial = RW'({rem, quo[DIV_STEPS-1]});
    ge    = (trial >= {1'b0, freq_q});
    diff  = trial - {1'b0, freq_q};
  end

  // Quotient saturation into the oscillator's register range, never zero.
  always_comb begin
    qx = QXW'(quo);
    if (qx == '0)
      clamp_val = N_BITS_P'(1);
    else if (qx > QMAX)
      clamp_val = '1;
    else
      clamp_val = N_BITS_P'(qx);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cfg_ready       <= 1'b1;
      cfg_error       <= 1'b0;
      cr_update       <= 1'b0;
      cr_clock_enable <= N_BITS_P'(1);
      cr_duty_cycle   <= '0;
      freq_q          <= '0;
      duty_q          <= '0;
      rem             <= '0;
      quo             <= '0;
      cnt             <= '0;
      q_clamp         <= '0;
      acc             <= '0;
      mcand           <= '0;
      mplier          <= '0;
    end else begin
      cr_update <= 1'b0;
      cfg_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cfg_ready) begin
            // One idle cycle after a commit before the next request.
            cfg_ready <= 1'b1;
          end else if (cfg_valid) begin
            cfg_ready <= 1'b0;
            freq_q    <= cfg_frequency;
            duty_q    <= cfg_duty;
            if (cfg_frequency == '0) begin
              cfg_error <= 1'b1;
              state     <= S_ERROR;
            end else begin
              // Upper dividend bits are always below the divisor, so they
              // preload the remainder; the low bits are shifted in per step.
              rem   <= RW'(dividend >> DIV_STEPS);
              quo   <= DIV_STEPS'(dividend);
              cnt   <= '0;
              state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          rem <= ge ? diff : trial;
          quo <= {quo[DIV_STEPS-2:0], ge};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DIV_STEPS - 1))
            state <= S_CLAMP;
        end
        S_CLAMP: begin
          q_clamp <= clamp_val;
          mcand   <= PW'(clamp_val);
          mplier  <= duty_q;
          acc     <= '0;
          cnt     <= '0;
          state   <= S_MULTIPLY;
        end
        S_MULTIPLY: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(DUTY_WIDTH_P - 1))
            state <= S_COMMIT;
        end
        S_COMMIT: begin
          cr_clock_enable <= q_clamp;
          cr_duty_cycle   <= N_BITS_P'(acc >> DUTY_WIDTH_P);
          cr_update       <= 1'b1;
          state           <= S_IDLE;
        end
        S_ERROR: begin
          cfg_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cfg_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_square_cfg_calc.sv
// Bench for osc_square_cfg_calc: directed scenarios plus randomized requests,
// all checked every cycle against a cycle-level reference model.
module tb_osc_square_cfg_calc;

  localparam int  PRIME = 1_000_000;
  localparam int  NB    = 20;
  localparam int  FW    = 24;
  localparam int  DW    = 8;
`ifdef OSC_SQUARE_CFG_CALC_ROUND_EN
  localparam int  LAT   = 32;
  localparam bit  RND   = 1'b1;
`else
  localparam int  LAT   = 31;
  localparam bit  RND   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [FW-1:0] cfg_frequency = '0;
  logic [DW-1:0] cfg_duty = '0;
  logic [NB-1:0] cr_clock_enable;
  logic [NB-1:0] cr_duty_cycle;
  logic          cr_update;
  logic          cfg_error;

  int n_chk = 0;
  int n_err = 0;
  int n_upd = 0;
  int n_errp = 0;

  osc_square_cfg_calc #(
    .PRIME_FREQUENCY_P(PRIME),
    .N_BITS_P(NB),
    .FREQ_WIDTH_P(FW),
    .DUTY_WIDTH_P(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_frequency(cfg_frequency),
    .cfg_duty(cfg_duty),
    .cr_clock_enable(cr_clock_enable),
    .cr_duty_cycle(cr_duty_cycle),
    .cr_update(cr_update),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint ref_ce(input longint f);
    longint q;
    q = RND ? (PRIME + f / 2) / f : PRIME / f;
    if (q == 0) q = 1;
    if (q > (longint'(1) << NB) - 1) q = (longint'(1) << NB) - 1;
    return q;
  endfunction

  function automatic longint ref_dc(input longint f, input longint d);
    return (ref_ce(f) * d) >> DW;
  endfunction

  // Reference model: tracks committed values and the cycles where ready,
  // update and error are due; compares every output every cycle.
  longint k = 0;
  longint ready_at = 0, upd_at = -1, err_at = -1;
  longint m_ce = 1, m_dc = 0, p_ce = 0, p_dc = 0;
  bit     armed = 1'b0;

  always @(negedge clk) begin
    k++;
    if (k == upd_at) begin
      m_ce = p_ce;
      m_dc = p_dc;
    end
    if (cr_update === 1'b1) n_upd++;
    if (cfg_error === 1'b1) n_errp++;
    if (armed) begin
      chk("ready", cfg_ready, longint'(k >= ready_at));
      chk("update", cr_update, longint'(k == upd_at));
      chk("error", cfg_error, longint'(k == err_at));
      chk("clock_enable", cr_clock_enable, m_ce);
      chk("duty_cycle", cr_duty_cycle, m_dc);
    end
    if (rst) begin
      armed = 1'b1;
      m_ce = 1; m_dc = 0;
      ready_at = k + 1; upd_at = -1; err_at = -1;
    end else if (armed && cfg_valid && k >= ready_at) begin
      if (cfg_frequency == 0) begin
        err_at   = k + 1;
        ready_at = k + 2;
      end else begin
        p_ce     = ref_ce(cfg_frequency);
        p_dc     = ref_dc(cfg_frequency, cfg_duty);
        upd_at   = k + LAT;
        ready_at = k + LAT + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until it is accepted.
  task automatic send(input int f, input int d);
    bit done = 1'b0;
    cfg_valid     = 1'b1;
    cfg_frequency = FW'(f);
    cfg_duty      = DW'(d);
    for (int g = 0; g < 200 && !done; g++) begin
      if (cfg_ready) done = 1'b1;
      step();
    end
    if (!done) chk("accept_timeout", 0, 1);
    cfg_valid     = 1'b0;
    cfg_frequency = FW'($urandom);
    cfg_duty      = DW'($urandom);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      if (cfg_ready) done = 1'b1;
      else step();
    end
    if (!done) chk("idle_timeout", 0, 1);
    step();
  endtask

  int u0;
  int f, d;

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_ce", cr_clock_enable, 1);
    chk("rst_dc", cr_duty_cycle, 0);

    // Basic conversion
    u0 = n_upd;
    send(1000, 128);
    wait_idle();
    chk("basic_ce", cr_clock_enable, RND ? 1000 : 1000);
    chk("basic_dc", cr_duty_cycle, 500);
    chk("basic_updates", n_upd - u0, 1);

    // Rounding-sensitive request
    send(6, 255);
    wait_idle();
    chk("round_ce", cr_clock_enable, RND ? 166667 : 166666);
    chk("round_dc", cr_duty_cycle, RND ? 166015 : 166014);

    // Frequency above prime: quotient 0 clamps to 1
    u0 = n_upd;
    send(2_000_000, 128);
    wait_idle();
    chk("clamp_ce", cr_clock_enable, 1);
    chk("clamp_dc", cr_duty_cycle, 0);
    chk("clamp_updates", n_upd - u0, 1);

    // Zero frequency rejected, outputs untouched
    send(1000, 128);
    wait_idle();
    u0 = n_upd;
    d = n_errp;
    send(0, 77);
    wait_idle();
    chk("err_pulses", n_errp - d, 1);
    chk("err_updates", n_upd - u0, 0);
    chk("err_ce", cr_clock_enable, 1000);
    chk("err_dc", cr_duty_cycle, 500);

    // Backpressure: second request held while the first computes
    u0 = n_upd;
    send(500, 64);
    send(3000, 200);
    wait_idle();
    chk("bp_updates", n_upd - u0, 2);
    chk("bp_ce", cr_clock_enable, ref_ce(3000));
    chk("bp_dc", cr_duty_cycle, ref_dc(3000, 200));

    // Reset during the divide aborts the request
    u0 = n_upd;
    send(7, 100);
    repeat (9) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("abort_ready", cfg_ready, 1);
    chk("abort_ce", cr_clock_enable, 1);
    chk("abort_dc", cr_duty_cycle, 0);
    repeat (40) step();
    chk("abort_updates", n_upd - u0, 0);

    // Randomized requests with random gaps; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: f = 0;
        1: f = $urandom_range(1, 20);
        2: f = $urandom_range(PRIME - 10, PRIME + 2_000_000);
        default: f = $urandom_range(1, 1 << FW - 1);
      endcase
      d = $urandom_range(0, 255);
      send(f, d);
      repeat ($urandom_range(0, 40)) step();
    end
    wait_idle();
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
